spi_led_ctrl: RTL and testbench

- SPI slave LED controller for the Zybo Z7-20 board.
- Receives 24-bit command frames from an external SPI master: 8-bit command, 8-bit address, 8-bit payload.
- Decodes LED-set commands into eight 7-bit brightness registers.
- Drives eight LED outputs through per-LED PWM generators, all in the sysclk domain (125 MHz).

---
 rtl/spi_led_ctrl_pkg.sv | 19 +
 rtl/spi_led_ctrl_if.sv | 10 +
 rtl/spi_slave_rx.sv | 62 ++++++
 rtl/spi_led_ctrl.sv | 44 ++++
 tb/tb_spi_led_ctrl.sv | 105 ++++++++++
 5 files changed

// File: rtl/spi_led_ctrl_pkg.sv
// spi_led_ctrl_pkg: frame layout, command codes and sizing shared by the LED controller.
package spi_led_ctrl_pkg;
    localparam int CMD_BITS     = 8;
    localparam int ADDR_BITS    = 8;
    localparam int PAYLOAD_BITS = 8;
    localparam int FRAME_WIDTH  = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
    localparam int NUM_LEDS     = 8;
    localparam int PWM_BITS     = PAYLOAD_BITS - 1;
    localparam int LED_AW       = $clog2(NUM_LEDS);
    localparam logic [CMD_BITS-1:0]     CMD_NOP      = 8'h00;
    localparam logic [CMD_BITS-1:0]     CMD_LED_SET  = 8'h01;
    localparam logic [ADDR_BITS-1:0]    ADDR_NONE    = 8'hFF;
    localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_NONE = 8'h00;
    typedef struct packed {
        logic [CMD_BITS-1:0]     cmd;
        logic [ADDR_BITS-1:0]    addr;
        logic [PAYLOAD_BITS-1:0] payload;
    } frame_t;
endpackage

// File: rtl/spi_led_ctrl_if.sv
// spi_led_ctrl_if: SPI pins plus the eight LED outputs of the controller.
interface spi_led_ctrl_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;
    logic led1, led2, led3, led4, led5, led6, led7, led8;
    modport master(output sclk, cs, mosi, input miso, led1, led2, led3, led4, led5, led6, led7, led8);
    modport slave(input sclk, cs, mosi, output miso, led1, led2, led3, led4, led5, led6, led7, led8);
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: mode-0 SPI slave oversampled on sysclk; captures 24-bit frames and echoes the last one on miso.
module spi_slave_rx
    import spi_led_ctrl_pkg::*;
(
    input  logic   sysclk,
    input  logic   rst,
    input  logic   sclk,
    input  logic   cs,
    input  logic   mosi,
    output logic   miso,
    output frame_t frame,
    output logic   rx_dv
);
    logic [2:0] sclk_sr, cs_sr;
    logic [1:0] mosi_sr;
    logic [FRAME_WIDTH-1:0] shift, echo;
    logic [4:0] cnt;
    logic active;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
    assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
    assign cs_fall   = ~cs_sr[1] & cs_sr[2];
    assign cs_rise   = cs_sr[1] & ~cs_sr[2];
    assign miso      = active & echo[FRAME_WIDTH-1];
    // active is only set by a seen cs fall, so a frame cut by reset cannot complete
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sclk_sr <= '0;
            cs_sr   <= '0;
            mosi_sr <= '0;
            shift   <= '0;
            echo    <= '0;
            cnt     <= '0;
            active  <= 1'b0;
            frame   <= '0;
            rx_dv   <= 1'b0;
        end else begin
            sclk_sr <= {sclk_sr[1:0], sclk};
            cs_sr   <= {cs_sr[1:0], cs};
            mosi_sr <= {mosi_sr[0], mosi};
            rx_dv   <= 1'b0;
            if (cs_fall) begin
                cnt    <= '0;
                shift  <= '0;
                echo   <= frame;
                active <= 1'b1;
            end else if (cs_rise) begin
                active <= 1'b0;
                if (active && cnt == 5'(FRAME_WIDTH)) begin
                    frame <= shift;
                    rx_dv <= 1'b1;
                end
            end else if (active) begin
                if (sclk_rise) begin
                    shift <= {shift[FRAME_WIDTH-2:0], mosi_sr[1]};
                    cnt   <= &cnt ? cnt : cnt + 5'd1;
                end
                if (sclk_fall) echo <= {echo[FRAME_WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/spi_led_ctrl.sv
// spi_led_ctrl: SPI-programmed brightness registers driving eight PWM LEDs.
module spi_led_ctrl
    import spi_led_ctrl_pkg::*;
(
    input  logic           sysclk,
    input  logic           rst,
    spi_led_ctrl_if.slave  bus
);
    frame_t frame;
    logic rx_dv;
    logic [PWM_BITS-1:0] bright [NUM_LEDS];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0] led;
    spi_slave_rx u_rx (
        .sysclk(sysclk),
        .rst(rst),
        .sclk(bus.sclk),
        .cs(bus.cs),
        .mosi(bus.mosi),
        .miso(bus.miso),
        .frame(frame),
        .rx_dv(rx_dv)
    );
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            led     <= '0;
            for (int i = 0; i < NUM_LEDS; i++) bright[i] <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            for (int i = 0; i < NUM_LEDS; i++) led[i] <= pwm_cnt < bright[i];
            if (rx_dv && frame.cmd == CMD_LED_SET && frame.addr < 8'(NUM_LEDS))
                bright[frame.addr[LED_AW-1:0]] <= PWM_BITS'(frame.payload >> 1);
        end
    end
    assign bus.led1 = led[0];
    assign bus.led2 = led[1];
    assign bus.led3 = led[2];
    assign bus.led4 = led[3];
    assign bus.led5 = led[4];
    assign bus.led6 = led[5];
    assign bus.led7 = led[6];
    assign bus.led8 = led[7];
endmodule

// File: tb/tb_spi_led_ctrl.sv
// tb_spi_led_ctrl: directed SPI frames with PWM duty and miso echo checks.
module tb_spi_led_ctrl;
    import spi_led_ctrl_pkg::*;
    typedef int arr8_t [8];
    logic sysclk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int hi [8];
    logic [23:0] echo_a, echo_b;
    logic [7:0] leds;
    logic m;
    spi_led_ctrl_if bus();
    spi_led_ctrl dut (.sysclk(sysclk), .rst(rst), .bus(bus));
    always #4 sysclk = ~sysclk;
    assign leds = {bus.led8, bus.led7, bus.led6, bus.led5, bus.led4, bus.led3, bus.led2, bus.led1};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic bit_tx(input logic b, output logic mo);
        bus.mosi = b;
        repeat (4) @(negedge sysclk);
        mo = bus.miso;
        bus.sclk = 1'b1;
        repeat (4) @(negedge sysclk);
        bus.sclk = 1'b0;
    endtask
    task automatic send(input logic [23:0] f, input int nbits, output logic [23:0] echo);
        logic mo;
        echo = '0;
        bus.cs = 1'b0;
        repeat (4) @(negedge sysclk);
        for (int i = 0; i < nbits; i++) begin
            bit_tx(f[23-i], mo);
            echo[23-i] = mo;
        end
        repeat (4) @(negedge sysclk);
        bus.cs = 1'b1;
        repeat (8) @(negedge sysclk);
    endtask
    task automatic check_leds(input string tag, input arr8_t e);
        hi = '{default: 0};
        repeat (128) begin
            @(negedge sysclk);
            for (int i = 0; i < 8; i++) hi[i] += int'(leds[i]);
        end
        for (int i = 0; i < 8; i++) check($sformatf("%s_led%0d", tag, i + 1), hi[i], e[i]);
    endtask
    initial begin
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        bus.mosi = 1'b0;
        repeat (3) @(negedge sysclk);
        check("rst_leds", leds, 8'h00);
        check("rst_miso", bus.miso, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge sysclk);
        send({CMD_NOP, ADDR_NONE, PAYLOAD_NONE}, 24, echo_a);
        check_leds("nop_a", '{0, 0, 0, 0, 0, 0, 0, 0});
        check_leds("nop_b", '{0, 0, 0, 0, 0, 0, 0, 0});
        send({CMD_LED_SET, 8'h00, 8'h14}, 24, echo_a);
        check_leds("set0", '{10, 0, 0, 0, 0, 0, 0, 0});
        send({CMD_LED_SET, 8'h07, 8'h14}, 24, echo_a);
        send({CMD_LED_SET, 8'hFF, 8'hFF}, 24, echo_a);
        send({CMD_LED_SET, 8'h10, 8'hFF}, 24, echo_a);
        check_leds("bad_addr", '{10, 0, 0, 0, 0, 0, 0, 10});
        send({CMD_LED_SET, 8'h03, 8'h16}, 24, echo_a);
        check_leds("led4_11", '{10, 0, 0, 11, 0, 0, 0, 10});
        send({CMD_LED_SET, 8'h03, 8'h00}, 24, echo_a);
        check_leds("led4_off", '{10, 0, 0, 0, 0, 0, 0, 10});
        send({CMD_LED_SET, 8'h02, 8'h40}, 16, echo_a);
        check_leds("trunc", '{10, 0, 0, 0, 0, 0, 0, 10});
        bus.cs = 1'b0;
        repeat (4) @(negedge sysclk);
        for (int i = 0; i < 8; i++) bit_tx(1'b0, m);
        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        check("midrst_leds", leds, 8'h00);
        check("midrst_miso", bus.miso, 1'b0);
        rst = 1'b0;
        for (int i = 8; i < 24; i++) begin
            logic [23:0] f;
            f = {CMD_LED_SET, 8'h05, 8'h20};
            bit_tx(f[23-i], m);
        end
        repeat (4) @(negedge sysclk);
        bus.cs = 1'b1;
        repeat (8) @(negedge sysclk);
        check_leds("post_rst", '{0, 0, 0, 0, 0, 0, 0, 0});
        send({CMD_LED_SET, 8'h05, 8'h20}, 24, echo_a);
        check("echo_rst", echo_a, 24'h000000);
        check_leds("led6_16", '{0, 0, 0, 0, 0, 16, 0, 0});
        send({CMD_LED_SET, 8'h02, 8'h0A}, 24, echo_a);
        send({CMD_NOP, ADDR_NONE, PAYLOAD_NONE}, 24, echo_b);
        check("echo_a", echo_a, 24'h010520);
        check("echo_b", echo_b, 24'h01020A);
        check_leds("led3_5", '{0, 0, 5, 0, 0, 16, 0, 0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
